// File: rtl/core_v_mini_mcu_pkg.sv
// MCU-level constants used by the peripheral register-bus arbiter.
package core_v_mini_mcu_pkg;

  localparam int unsigned PeriphArbTimeoutCycles = 255;
  localparam logic [31:0] PeriphArbAbortRdata    = 32'hBADCAB1E;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } periph_arb_state_e;

  // Successor of idx in a ring of num entries.
  function automatic int unsigned periph_arb_next(input int unsigned idx, input int unsigned num);
    return (idx + 1 >= num) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/reg_pkg.sv
// Register-bus request/response types shared by the peripheral interconnect.
package reg_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

// File: rtl/periph_reg_arbiter_if.sv
// Bundle of the arbiter's requester-side and peripheral-side bus signals.
interface periph_reg_arbiter_if #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = $clog2(NumReq)
);

  reg_pkg::reg_req_t [NumReq-1:0] req;
  reg_pkg::reg_rsp_t [NumReq-1:0] rsp;
  reg_pkg::reg_req_t              bus_req;
  reg_pkg::reg_rsp_t              bus_rsp;
  logic [IdxW-1:0]                grant_idx;
  logic                           busy;
  logic                           timeout;

  // master: requesters plus the peripheral side; slave: the arbiter itself.
  modport master (
    output req, bus_rsp,
    input  rsp, bus_req, grant_idx, busy, timeout
  );

  modport slave (
    input  req, bus_rsp,
    output rsp, bus_req, grant_idx, busy, timeout
  );

endinterface

// File: rtl/periph_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr_i, wrapping.
module periph_rr_pick #(
  parameter int unsigned NumReq = 2
) (
  input  logic [NumReq-1:0]         valid_i,
  input  logic [$clog2(NumReq)-1:0] ptr_i,
  output logic [$clog2(NumReq)-1:0] idx_o,
  output logic                      found_o
);

  localparam int unsigned IdxW = $clog2(NumReq);

  logic [IdxW-1:0] cand [NumReq];

  always_comb begin
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand[k] = IdxW'((int'(ptr_i) + k) % NumReq);
    end
  end

  // Earlier positions in the search order take priority.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (!found_o && valid_i[cand[k]]) begin
        idx_o   = cand[k];
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/periph_reg_arbiter.sv
// Round-robin arbiter funnelling several register-bus requesters onto one
// peripheral bus, one outstanding transaction at a time, with a BUSY timeout.
module periph_reg_arbiter
  import core_v_mini_mcu_pkg::*;
#(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned TimeoutCycles = PeriphArbTimeoutCycles
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  reg_pkg::reg_req_t [NumReq-1:0] req_i,
  output reg_pkg::reg_rsp_t [NumReq-1:0] rsp_o,
  output reg_pkg::reg_req_t              req_o,
  input  reg_pkg::reg_rsp_t              rsp_i,
  output logic [$clog2(NumReq)-1:0]      grant_idx_o,
  output logic                           busy_o,
  output logic                           timeout_o
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumReq - 1);
  localparam logic [CntW-1:0] CntMax   = CntW'(TimeoutCycles);
  localparam logic [CntW-1:0] CntAbort = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  periph_arb_state_e state_q, state_d;
  logic [IdxW-1:0]   grant_q, grant_d;
  logic [IdxW-1:0]   last_grant_q, last_grant_d;
  reg_pkg::reg_req_t payload_q, payload_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [NumReq-1:0] req_valid;
  logic [IdxW-1:0]   rr_ptr;
  logic [IdxW-1:0]   pick_idx;
  logic              pick_found;
  logic              abort_due;

  always_comb begin
    for (int unsigned n = 0; n < NumReq; n++) begin
      req_valid[n] = req_i[n].valid;
    end
  end

  assign rr_ptr = IdxW'(periph_arb_next(int'(last_grant_q), NumReq));

  periph_rr_pick #(
    .NumReq (NumReq)
  ) u_rr_pick (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign abort_due = (TimeoutCycles != 0) && (cnt_q == CntAbort);

  // A real response on the abort cycle takes precedence over the timeout.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    payload_d    = payload_q;
    cnt_d        = cnt_q;
    rsp_o        = '0;
    timeout_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d         = pick_idx;
          payload_d       = req_i[pick_idx];
          payload_d.valid = 1'b0;
          cnt_d           = '0;
          state_d         = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (rsp_i.ready) begin
          rsp_o[grant_q].rdata = rsp_i.rdata;
          rsp_o[grant_q].error = rsp_i.error;
          rsp_o[grant_q].ready = 1'b1;
          last_grant_d         = grant_q;
          state_d              = IDLE;
        end else if (abort_due) begin
          rsp_o[grant_q].rdata = PeriphArbAbortRdata;
          rsp_o[grant_q].error = 1'b1;
          rsp_o[grant_q].ready = 1'b1;
          timeout_o            = 1'b1;
          last_grant_d         = grant_q;
          state_d              = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= LastIdx;
      payload_q    <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      payload_q    <= payload_d;
      cnt_q        <= cnt_d;
    end
  end

  // Payload fields stay stable in IDLE; only valid follows the state.
  always_comb begin
    req_o       = payload_q;
    req_o.valid = (state_q == BUSY);
  end

  assign busy_o      = (state_q == BUSY);
  assign grant_idx_o = grant_q;

endmodule

// File: doc/periph_reg_arbiter.md
PERIPH_REG_ARBITER -- requirements
Module: periph_reg_arbiter

Interface
REQ-001 The block SHALL have parameter NumReq, default 2, giving the number of register-bus requesters (legal range 2..8).
REQ-002 The block SHALL have parameter TimeoutCycles, default 255, giving the maximum number of BUSY cycles before abort; 0 disables the timeout.
REQ-003 The block SHALL have port clk_i, input, 1, the single clock; one clock, no other clock domains.
REQ-004 The block SHALL have port rst_ni, input, 1; reset is asynchronous and active-low.
REQ-005 The block SHALL have port req_i, input, [NumReq] x reg_pkg::reg_req_t, the requester-side requests.
REQ-006 The block SHALL have port rsp_o, output, [NumReq] x reg_pkg::reg_rsp_t, the requester-side responses.
REQ-007 The block SHALL have port req_o, output, reg_pkg::reg_req_t, the shared request toward the peripheral reg_demux.
REQ-008 The block SHALL have port rsp_i, input, reg_pkg::reg_rsp_t, the shared response from the peripheral reg_demux.
REQ-009 The block SHALL have port grant_idx_o, output, $clog2(NumReq), the index of the current or last granted requester.
REQ-010 The block SHALL have port busy_o, output, 1, high while in BUSY.
REQ-011 The block SHALL have port timeout_o, output, 1, a one-cycle pulse on abort.

Function
REQ-012 The FSM SHALL have two states, IDLE and BUSY; the reset state SHALL be IDLE.
REQ-013 In IDLE, when any req_i[n].valid is high, the block SHALL select one requester round-robin, starting the search at (last_grant+1) mod NumReq.
REQ-014 On that IDLE cycle the block SHALL register the winner index and capture addr, write, wdata and wstrb into a payload register, then enter BUSY.
REQ-015 In BUSY, req_o SHALL be driven from the payload register with valid=1.
REQ-016 req_o.valid SHALL be 0 in IDLE, and req_o's other fields SHALL hold their last value.
REQ-017 Requester-to-bus latency SHALL be exactly one cycle: a valid seen in IDLE at cycle t gives req_o.valid at cycle t+1.
REQ-018 In BUSY, when rsp_i.ready=1, the block SHALL combinationally drive rsp_o[grant] = rsp_i (rdata, error, ready=1), update last_grant to grant, and return to IDLE next cycle.
REQ-019 rsp_o[n].ready SHALL be 0 for every non-granted n, and for all n in IDLE; rsp_o[n].rdata and .error SHALL be 0 whenever ready is 0.
REQ-020 Back-to-back transactions SHALL have exactly one IDLE cycle between a response and the next req_o.valid.
REQ-021 A granted requester that drops valid during BUSY SHALL NOT affect the transaction; its response is still delivered.
REQ-022 A BUSY-cycle counter SHALL clear on entry to BUSY and saturate at TimeoutCycles.
REQ-023 If TimeoutCycles != 0 and the counter equals TimeoutCycles-1 with rsp_i.ready=0, the block SHALL drive rsp_o[grant] with ready=1, error=1, rdata=32'hBADCAB1E, pulse timeout_o for one cycle, update last_grant, and go to IDLE.
REQ-024 If rsp_i.ready=1 on the timeout cycle, the real response SHALL win and timeout_o SHALL stay 0.
REQ-025 A late rsp_i.ready arriving in IDLE SHALL be ignored.
REQ-026 Requests arriving during BUSY SHALL wait, with no starvation: each waiting requester is granted within NumReq transactions.

Reset
REQ-027 While rst_ni=0, the block SHALL force state=IDLE, last_grant=NumReq-1 (so requester 0 wins first), grant_idx_o=0, payload=0, counter=0, busy_o=0, timeout_o=0, req_o all-zero, and all rsp_o all-zero.
REQ-028 Reset asserted mid-BUSY SHALL drop the transaction silently, with no response to the requester.

Structure
REQ-029 TimeoutCycles default, the abort pattern 32'hBADCAB1E and the state enum SHALL live in core_v_mini_mcu_pkg; reg_req_t/reg_rsp_t SHALL come from reg_pkg.
REQ-030 The round-robin selection SHALL be a single sub-module, periph_rr_pick (combinational: valid vector and pointer in, index and found out).
REQ-031 The block SHALL sit between periph_to_reg and reg_demux and SHALL contain no clock gating.

Verification
REQ-032 Single request: req_i[0] write addr 0x20000010, wdata 0xA5A5A5A5; rsp_i.ready one cycle after req_o.valid -> req_o.valid at t+1 with the captured payload, rsp_o[0].ready at t+2, busy_o high for 2 cycles.
REQ-033 Round-robin: req_i[0] and req_i[1] held valid continuously out of reset -> grant order 0,1,0,1, with one IDLE cycle between grants.
REQ-034 Timeout: TimeoutCycles=4, rsp_i.ready never asserted -> after 4 BUSY cycles rsp_o[g] has ready=1, error=1, rdata=0xBADCAB1E and timeout_o pulses once.
REQ-035 Race: rsp_i.ready=1 with rdata=0x12345678 on the same cycle the timeout would fire -> rsp_o.rdata=0x12345678, error=0, timeout_o=0.
REQ-036 Reset mid-BUSY: rst_ni pulled low while BUSY -> all outputs zero immediately; after release, the first grant goes to requester 0.
REQ-037 Valid dropped: requester 1 deasserts valid mid-BUSY -> req_o payload is unchanged and rsp_o[1].ready is still delivered.
